pipelined_controller: RTL and testbench
=======================================

// Module: pipelined_controller
// PURPOSE
//  Pipelined successor to the single-cycle ARM controller. Decodes InstrD in Decode, then carries
//  control through E/M/W pipeline registers and holds an architectural NZCV flag register.
//  Conditional execution is evaluated in Execute against the stored flags. Taken branches in
//  Execute squash the younger instruction. Sits beside the 5-stage datapath and hazard unit.
// PARAMETERS
//  ALUCTRL_W  4  width of ALUControl; codes zero-extended into this width
//  CMP_TST_EN 1  1: decode CMP (funct 1010) as SUB and TST (1000) as AND, no RegWrite, forced S
//  SPLIT_CV   1  1: logical ops update only N,Z (C,V held); 0: all four flags written
// PORTS
//  clk          in   1          clock, rising edge
//  reset        in   1          asynchronous, active-low reset
//  InstrD       in   32         instruction in Decode
//  ALUFlags     in   4          {N,Z,C,V} from ALU, Execute-stage instruction
//  FlushE       in   1          hazard unit: load a bubble into E next edge (load-use)
//  RegSrcD      out  2          Decode: register-address select (comb.)
//  ImmSrcD      out  2          Decode: extend select (comb.)
//  ALUSrcE      out  1          Execute: 1 = immediate operand B
//  ALUControlE  out  ALUCTRL_W  Execute: ALU op
//  MemtoRegE    out  1          Execute: load in E (hazard unit, load-use)
//  BranchTakenE out  1          Execute: branch valid and condition passes
//  RegWriteM    out  1          Memory: qualified register write (forwarding)
//  MemWriteM    out  1          Memory: qualified store strobe
//  RegWriteW    out  1          Writeback: qualified register write
//  MemtoRegW    out  1          Writeback: 1 = write ReadData
//  FlagsOut     out  4          current NZCV register
// BEHAVIOUR
//  Reset (reset=0, async): all E/M/W registers and FlagsOut clear to 0. All outputs except the
//   combinational RegSrcD/ImmSrcD read 0 until the first instruction reaches each stage.
//  Decode (comb., op=Instr[27:26]):
//   DP 00: RegW=1, ALUSrc=I[25], ImmSrc=00, RegSrc=00.
//   Mem 01: ALUSrc=1, ImmSrc=01, RegSrc=10, ALU=ADD. LDR (bit20=1): RegW, MemtoReg. STR: MemW.
//   Br 10: ALUSrc=1, ImmSrc=10, RegSrc=01, ALU=ADD, Branch=1.
//   op=11: no writes, no branch.
//  ALU codes: AND 0000, ORR 0001, EOR 0010, ADD 0011, SUB 1011. funct 0000->AND, 0001->EOR,
//   0010->SUB, 0100->ADD, 1100->ORR; other funct values->ADD.
//  With CMP_TST_EN=1: 1010->SUB and 1000->AND, both with RegW=0 and FlagW forced to 1.
//  FlagWrite decode: DP with S=1 (bit20), or CMP/TST.
//  D->E edge: E regs load {valid=1, decoded ctrl, cond, FlagW, arith}. arith=1 for ADD/SUB/CMP.
//   Load a bubble instead (valid=0, all ctrl 0) if FlushE=1 or BranchTakenE=1 on that edge.
//  Execute: CondEx is evaluated from cond (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL; 1111 = never)
//   against FlagsOut, not ALUFlags.
//   Qualified = raw & validE & CondEx, applied to RegWrite, MemWrite, Branch and FlagWrite.
//  Flag update: on the edge ending E, if qualified FlagW: N,Z<=ALUFlags[3:2].
//   C,V<=ALUFlags[1:0] only if arith or SPLIT_CV=0; otherwise C,V are held.
//  Back-to-back: an instruction in E sees flags from the instruction that left E on the
//   previous edge, so no forwarding is needed.
//  E->M->W: qualified RegWrite/MemWrite/MemtoReg shift 1 stage per edge. No stalls beyond E.
//   RegWriteW is asserted exactly 3 edges after InstrD is sampled.
//  Taken branch: BranchTakenE=1 for one cycle. The D instruction becomes an E bubble. The datapath
//   uses BranchTakenE to redirect the PC and flush F/D.
//  FlushE and BranchTakenE together give a single bubble with identical effect.
//  Failed-condition instruction: propagates as an all-zero-control slot and has no side effects.
//  Reset asserted mid-stream: all in-flight control is discarded at once and flags clear.
// TESTING
//  Reset, then stream ADD R1,R2,R3 (E0821003) -> ALUControlE=0011 one edge later; RegWriteW=1 at edge 3.
//  SUBS R1,R1,#1 (E2511001) with ALUFlags=0100 -> FlagsOut=0100 the next cycle.
//   Then BEQ (0A000002) -> BranchTakenE=1, and the following slot has RegWriteM=0.
//  FlagsOut=0011, then ANDS (E0110002) with ALUFlags=1000 -> FlagsOut=1011 (SPLIT_CV=1),
//   or FlagsOut=1000 (SPLIT_CV=0).
//  CMP R1,#0 (E3510000) -> ALUControlE=1011, RegWriteM=0, flags written.
//   With CMP_TST_EN=0 -> decoded as ADD, RegWrite=1.
//  LDR (E5910004) -> MemtoRegE=1, RegWriteW=1, MemtoRegW=1; STR (E5810004) -> MemWriteM=1.
//   NE-conditioned STR with Z=1 -> MemWriteM=0.
//  FlushE pulse with ADD in D -> no RegWriteW for it.
//   Assert reset=0 with 3 instructions in flight -> all outputs 0 and FlagsOut=0000 immediately.

Source files
------------

// File: rtl/pipelined_controller.sv
// Pipelined ARM control unit: combinational decode in D, control carried through E/M/W
// registers, conditional execution resolved in E against the stored NZCV register.
module pipelined_controller #(
  parameter int unsigned ALUCTRL_W  = 4,
  parameter bit          CMP_TST_EN = 1'b1,
  parameter bit          SPLIT_CV   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrD,
  input  logic [3:0]           ALUFlags,
  input  logic                 FlushE,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ImmSrcD,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 MemtoRegE,
  output logic                 BranchTakenE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic [3:0]           FlagsOut
);

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOrr = 4'b0001;
  localparam logic [3:0] AluEor = 4'b0010;
  localparam logic [3:0] AluAdd = 4'b0011;
  localparam logic [3:0] AluSub = 4'b1011;

  logic [1:0] op;
  logic [3:0] funct;
  assign op    = InstrD[27:26];
  assign funct = InstrD[24:21];

  // Immediate/register fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^InstrD[19:0];

  // Decode-stage control
  logic [1:0] reg_src_d, imm_src_d;
  logic       alu_src_d, reg_write_d, mem_write_d, mem_to_reg_d, branch_d;
  logic       flag_write_d, arith_d;
  logic [3:0] alu_op_d;

  // Execute-stage registers
  logic                 valid_e_q, alu_src_e_q, reg_write_e_q, mem_write_e_q, mem_to_reg_e_q;
  logic                 branch_e_q, flag_write_e_q, arith_e_q;
  logic [ALUCTRL_W-1:0] alu_ctrl_e_q;
  logic [3:0]           cond_e_q;

  // Memory / writeback registers and flags
  logic       reg_write_m_q, mem_write_m_q, mem_to_reg_m_q;
  logic       reg_write_w_q, mem_to_reg_w_q;
  logic [3:0] flags_q;

  logic cond_ex, qual_e, branch_taken_e, bubble_e;

  // Main decoder plus ALU decoder, purely from the instruction in D.
  always_comb begin
    reg_src_d    = 2'b00;
    imm_src_d    = 2'b00;
    alu_src_d    = 1'b0;
    alu_op_d     = AluAdd;
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    branch_d     = 1'b0;
    flag_write_d = 1'b0;
    arith_d      = 1'b0;
    unique case (op)
      2'b00: begin
        reg_write_d  = 1'b1;
        alu_src_d    = InstrD[25];
        flag_write_d = InstrD[20];
        case (funct)
          4'b0000: alu_op_d = AluAnd;
          4'b0001: alu_op_d = AluEor;
          4'b0010: alu_op_d = AluSub;
          4'b0100: alu_op_d = AluAdd;
          4'b1100: alu_op_d = AluOrr;
          default: alu_op_d = AluAdd;
        endcase
        // CMP/TST: compare-only forms, always set flags and never write a register.
        if (CMP_TST_EN && (funct == 4'b1010)) begin
          alu_op_d     = AluSub;
          reg_write_d  = 1'b0;
          flag_write_d = 1'b1;
        end
        if (CMP_TST_EN && (funct == 4'b1000)) begin
          alu_op_d     = AluAnd;
          reg_write_d  = 1'b0;
          flag_write_d = 1'b1;
        end
        arith_d = (alu_op_d == AluAdd) || (alu_op_d == AluSub);
      end
      2'b01: begin
        alu_src_d    = 1'b1;
        imm_src_d    = 2'b01;
        reg_src_d    = 2'b10;
        alu_op_d     = AluAdd;
        reg_write_d  = InstrD[20];
        mem_to_reg_d = InstrD[20];
        mem_write_d  = ~InstrD[20];
      end
      2'b10: begin
        alu_src_d = 1'b1;
        imm_src_d = 2'b10;
        reg_src_d = 2'b01;
        alu_op_d  = AluAdd;
        branch_d  = 1'b1;
      end
      default: begin
        alu_op_d = AluAdd;
      end
    endcase
  end

  // Condition check against the architectural flags (not the in-flight ALU flags).
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    case (cond_e_q)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign qual_e         = valid_e_q & cond_ex;
  assign branch_taken_e = branch_e_q & qual_e;
  // A taken branch squashes the younger D instruction exactly like a load-use flush.
  assign bubble_e       = FlushE | branch_taken_e;

  // D->E pipeline register; a bubble clears every control bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_e_q      <= 1'b0;
      alu_src_e_q    <= 1'b0;
      alu_ctrl_e_q   <= '0;
      reg_write_e_q  <= 1'b0;
      mem_write_e_q  <= 1'b0;
      mem_to_reg_e_q <= 1'b0;
      branch_e_q     <= 1'b0;
      flag_write_e_q <= 1'b0;
      arith_e_q      <= 1'b0;
      cond_e_q       <= 4'b0000;
    end else if (bubble_e) begin
      valid_e_q      <= 1'b0;
      alu_src_e_q    <= 1'b0;
      alu_ctrl_e_q   <= '0;
      reg_write_e_q  <= 1'b0;
      mem_write_e_q  <= 1'b0;
      mem_to_reg_e_q <= 1'b0;
      branch_e_q     <= 1'b0;
      flag_write_e_q <= 1'b0;
      arith_e_q      <= 1'b0;
      cond_e_q       <= 4'b0000;
    end else begin
      valid_e_q      <= 1'b1;
      alu_src_e_q    <= alu_src_d;
      alu_ctrl_e_q   <= ALUCTRL_W'(alu_op_d);
      reg_write_e_q  <= reg_write_d;
      mem_write_e_q  <= mem_write_d;
      mem_to_reg_e_q <= mem_to_reg_d;
      branch_e_q     <= branch_d;
      flag_write_e_q <= flag_write_d;
      arith_e_q      <= arith_d;
      cond_e_q       <= InstrD[31:28];
    end
  end

  // E->M->W shift of the qualified control; failed conditions become all-zero slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
    end else begin
      reg_write_m_q  <= reg_write_e_q & qual_e;
      mem_write_m_q  <= mem_write_e_q & qual_e;
      mem_to_reg_m_q <= mem_to_reg_e_q & qual_e;
      reg_write_w_q  <= reg_write_m_q;
      mem_to_reg_w_q <= mem_to_reg_m_q;
    end
  end

  // NZCV register; logical ops may leave C,V untouched when SPLIT_CV is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else if (flag_write_e_q && qual_e) begin
      flags_q[3:2] <= ALUFlags[3:2];
      if (arith_e_q || !SPLIT_CV) begin
        flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign RegSrcD      = reg_src_d;
  assign ImmSrcD      = imm_src_d;
  assign ALUSrcE      = alu_src_e_q;
  assign ALUControlE  = alu_ctrl_e_q;
  assign MemtoRegE    = mem_to_reg_e_q;
  assign BranchTakenE = branch_taken_e;
  assign RegWriteM    = reg_write_m_q;
  assign MemWriteM    = mem_write_m_q;
  assign RegWriteW    = reg_write_w_q;
  assign MemtoRegW    = mem_to_reg_w_q;
  assign FlagsOut     = flags_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: writeback results tracked by a scoreboard queue, stage
// outputs checked inline per scenario.
module tb_pipelined_controller;

  localparam int unsigned ALUCTRL_W  = 4;
  localparam bit          CMP_TST_EN = 1'b1;
  localparam bit          SPLIT_CV   = 1'b1;

  localparam logic [31:0] I_ADD   = 32'hE082_1003;
  localparam logic [31:0] I_ADDNE = 32'h1082_1003;
  localparam logic [31:0] I_SUBS  = 32'hE251_1001;
  localparam logic [31:0] I_BEQ   = 32'h0A00_0002;
  localparam logic [31:0] I_ANDS  = 32'hE011_0002;
  localparam logic [31:0] I_CMP   = 32'hE351_0000;
  localparam logic [31:0] I_LDR   = 32'hE591_0004;
  localparam logic [31:0] I_STR   = 32'hE581_0004;
  localparam logic [31:0] I_STRNE = 32'h1581_0004;
  localparam logic [31:0] I_NOP   = 32'hEC00_0000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [31:0]          InstrD = I_NOP;
  logic [3:0]           ALUFlags = 4'b0000;
  logic                 FlushE = 1'b0;
  logic [1:0]           RegSrcD, ImmSrcD;
  logic                 ALUSrcE, MemtoRegE, BranchTakenE, RegWriteM, MemWriteM;
  logic                 RegWriteW, MemtoRegW;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic [3:0]           FlagsOut;

  int tests = 0;
  int fails = 0;
  int cycle_n = 0;

  typedef struct {int tag; logic [1:0] w;} sb_t;
  sb_t sb_q[$];

  pipelined_controller #(
    .ALUCTRL_W (ALUCTRL_W),
    .CMP_TST_EN(CMP_TST_EN),
    .SPLIT_CV  (SPLIT_CV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .InstrD      (InstrD),
    .ALUFlags    (ALUFlags),
    .FlushE      (FlushE),
    .RegSrcD     (RegSrcD),
    .ImmSrcD     (ImmSrcD),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .MemtoRegE   (MemtoRegE),
    .BranchTakenE(BranchTakenE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .RegWriteW   (RegWriteW),
    .MemtoRegW   (MemtoRegW),
    .FlagsOut    (FlagsOut)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One cycle: drive D-stage inputs, record the expected {RegWriteW,MemtoRegW} for this
  // instruction, and compare the oldest entry once it has had three edges to reach W.
  task automatic cyc(input logic [31:0] instr, input logic flush, input logic [3:0] af,
                     input logic [1:0] expw);
    sb_t e;
    InstrD   = instr;
    FlushE   = flush;
    ALUFlags = af;
    e.tag    = cycle_n;
    e.w      = expw;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cycle_n++;
    FlushE = 1'b0;
    if (sb_q.size() > 0 && sb_q[0].tag + 3 == cycle_n) begin
      e = sb_q.pop_front();
      tests++;
      if ({RegWriteW, MemtoRegW} !== e.w) begin
        fails++;
        $display("FAIL sb_writeback tag=%0d {RegWriteW,MemtoRegW} got=%b exp=%b",
                 e.tag, {RegWriteW, MemtoRegW}, e.w);
      end
    end
  endtask

  task automatic drain();
    repeat (4) cyc(I_NOP, 1'b0, 4'b0000, 2'b00);
  endtask

  task automatic test_reset();
    InstrD = I_LDR;
    #3;
    tests++;
    if ({ALUSrcE, ALUControlE, MemtoRegE, BranchTakenE, RegWriteM, MemWriteM, RegWriteW,
         MemtoRegW, FlagsOut} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%b exp=0", {ALUSrcE, ALUControlE, MemtoRegE,
               BranchTakenE, RegWriteM, MemWriteM, RegWriteW, MemtoRegW, FlagsOut});
    end
    tests++;
    if ({RegSrcD, ImmSrcD} !== 4'b1001) begin
      fails++;
      $display("FAIL reset_ldr_decode {RegSrcD,ImmSrcD} got=%b exp=1001", {RegSrcD, ImmSrcD});
    end
    InstrD = I_NOP;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_add();
    cyc(I_ADD, 1'b0, 4'b0000, 2'b10);
    tests++;
    if (ALUControlE !== 4'b0011 || ALUSrcE !== 1'b0) begin
      fails++;
      $display("FAIL add_exec ALUControlE=%b ALUSrcE=%b exp 0011/0", ALUControlE, ALUSrcE);
    end
    cyc(I_NOP, 1'b0, 4'b0000, 2'b00);
    tests++;
    if (RegWriteM !== 1'b1) begin
      fails++;
      $display("FAIL add_mem RegWriteM got=%b exp=1", RegWriteM);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    cyc(I_SUBS, 1'b0, 4'b0000, 2'b10);
    cyc(I_BEQ, 1'b0, 4'b0100, 2'b00);
    tests++;
    if (FlagsOut !== 4'b0100) begin
      fails++;
      $display("FAIL subs_flags FlagsOut got=%b exp=0100", FlagsOut);
    end
    tests++;
    if (BranchTakenE !== 1'b1) begin
      fails++;
      $display("FAIL beq_taken BranchTakenE got=%b exp=1", BranchTakenE);
    end
    tests++;
    if ({RegSrcD, ImmSrcD} !== 4'b0110) begin
      fails++;
      $display("FAIL beq_decode {RegSrcD,ImmSrcD} got=%b exp=0110", {RegSrcD, ImmSrcD});
    end
    // ADD in D while the branch is taken: squashed.
    cyc(I_ADD, 1'b0, 4'b0000, 2'b00);
    tests++;
    if (BranchTakenE !== 1'b0 || ALUControlE !== 4'b0000) begin
      fails++;
      $display("FAIL branch_bubble BranchTakenE=%b ALUControlE=%b exp 0/0000", BranchTakenE,
               ALUControlE);
    end
    cyc(I_ADD, 1'b0, 4'b0000, 2'b10);
    tests++;
    if (RegWriteM !== 1'b0) begin
      fails++;
      $display("FAIL branch_slot RegWriteM got=%b exp=0", RegWriteM);
    end
    drain();
  endtask

  task automatic test_split_cv();
    cyc(I_SUBS, 1'b0, 4'b0000, 2'b10);
    cyc(I_ANDS, 1'b0, 4'b0011, 2'b10);
    tests++;
    if (FlagsOut !== 4'b0011) begin
      fails++;
      $display("FAIL cv_setup FlagsOut got=%b exp=0011", FlagsOut);
    end
    cyc(I_NOP, 1'b0, 4'b1000, 2'b00);
    tests++;
    if (FlagsOut !== (SPLIT_CV ? 4'b1011 : 4'b1000)) begin
      fails++;
      $display("FAIL ands_flags FlagsOut got=%b exp=%b", FlagsOut,
               (SPLIT_CV ? 4'b1011 : 4'b1000));
    end
    drain();
  endtask

  task automatic test_cmp();
    cyc(I_CMP, 1'b0, 4'b0000, CMP_TST_EN ? 2'b00 : 2'b10);
    tests++;
    if (ALUControlE !== (CMP_TST_EN ? 4'b1011 : 4'b0011) || ALUSrcE !== 1'b1) begin
      fails++;
      $display("FAIL cmp_exec ALUControlE=%b ALUSrcE=%b", ALUControlE, ALUSrcE);
    end
    cyc(I_NOP, 1'b0, 4'b0110, 2'b00);
    tests++;
    if (FlagsOut !== 4'b0110) begin
      fails++;
      $display("FAIL cmp_flags FlagsOut got=%b exp=0110", FlagsOut);
    end
    tests++;
    if (RegWriteM !== !CMP_TST_EN) begin
      fails++;
      $display("FAIL cmp_regwrite RegWriteM got=%b exp=%b", RegWriteM, !CMP_TST_EN);
    end
    drain();
  endtask

  task automatic test_mem();
    cyc(I_LDR, 1'b0, 4'b0000, 2'b11);
    tests++;
    if (MemtoRegE !== 1'b1 || ALUSrcE !== 1'b1 || ALUControlE !== 4'b0011) begin
      fails++;
      $display("FAIL ldr_exec MemtoRegE=%b ALUSrcE=%b ALUControlE=%b exp 1/1/0011", MemtoRegE,
               ALUSrcE, ALUControlE);
    end
    cyc(I_STR, 1'b0, 4'b0000, 2'b00);
    tests++;
    if (RegWriteM !== 1'b1 || MemWriteM !== 1'b0 || MemtoRegE !== 1'b0) begin
      fails++;
      $display("FAIL ldr_mem RegWriteM=%b MemWriteM=%b MemtoRegE=%b exp 1/0/0", RegWriteM,
               MemWriteM, MemtoRegE);
    end
    cyc(I_NOP, 1'b0, 4'b0000, 2'b00);
    tests++;
    if (MemWriteM !== 1'b1 || RegWriteM !== 1'b0) begin
      fails++;
      $display("FAIL str_mem MemWriteM=%b RegWriteM=%b exp 1/0", MemWriteM, RegWriteM);
    end
    // Z=1 from the compare, so NE-conditioned instructions must fail.
    cyc(I_STRNE, 1'b0, 4'b0000, 2'b00);
    cyc(I_ADDNE, 1'b0, 4'b0000, 2'b00);
    tests++;
    if (MemWriteM !== 1'b0) begin
      fails++;
      $display("FAIL strne_mem MemWriteM got=%b exp=0", MemWriteM);
    end
    drain();
  endtask

  task automatic test_flush();
    cyc(I_ADD, 1'b1, 4'b0000, 2'b00);
    tests++;
    if (ALUControlE !== 4'b0000 || ALUSrcE !== 1'b0) begin
      fails++;
      $display("FAIL flush_bubble ALUControlE=%b ALUSrcE=%b exp 0000/0", ALUControlE, ALUSrcE);
    end
    // Flush and taken branch on the same edge: still a single bubble.
    cyc(I_BEQ, 1'b0, 4'b0000, 2'b00);
    cyc(I_ADD, 1'b1, 4'b0000, 2'b00);
    tests++;
    if (BranchTakenE !== 1'b0 || ALUControlE !== 4'b0000) begin
      fails++;
      $display("FAIL flush_branch BranchTakenE=%b ALUControlE=%b exp 0/0000", BranchTakenE,
               ALUControlE);
    end
    cyc(I_ADD, 1'b0, 4'b0000, 2'b10);
    tests++;
    if (ALUControlE !== 4'b0011) begin
      fails++;
      $display("FAIL post_flush ALUControlE got=%b exp=0011", ALUControlE);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    cyc(I_SUBS, 1'b0, 4'b0000, 2'b10);
    cyc(I_ADD, 1'b0, 4'b1111, 2'b10);
    cyc(I_LDR, 1'b0, 4'b0000, 2'b11);
    tests++;
    if (FlagsOut !== 4'b1111 || RegWriteM !== 1'b1 || MemtoRegE !== 1'b1) begin
      fails++;
      $display("FAIL inflight FlagsOut=%b RegWriteM=%b MemtoRegE=%b exp 1111/1/1", FlagsOut,
               RegWriteM, MemtoRegE);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({ALUSrcE, ALUControlE, MemtoRegE, BranchTakenE, RegWriteM, MemWriteM, RegWriteW,
         MemtoRegW, FlagsOut} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs got=%b exp=0", {ALUSrcE, ALUControlE, MemtoRegE,
               BranchTakenE, RegWriteM, MemWriteM, RegWriteW, MemtoRegW, FlagsOut});
    end
    sb_q.delete();
    InstrD = I_NOP;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(I_ADD, 1'b0, 4'b0000, 2'b10);
    tests++;
    if (ALUControlE !== 4'b0011) begin
      fails++;
      $display("FAIL recover ALUControlE got=%b exp=0011", ALUControlE);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_split_cv();
    test_cmp();
    test_mem();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
